// File: rtl/dzcpu_useq_if.sv
// dzcpu_useq_if: memory, flow-LUT, ucode-ROM and datapath signals of the micro-sequencer.
// oUopErr exists only when DZCPU_USEQ_WATCHDOG_EN is defined.
interface dzcpu_useq_if #(parameter int UOP_W = 12);
  logic             oFetchReq;
  logic             iMemValid;
  logic [7:0]       iMemData;
  logic [7:0]       oLutMop;
  logic             oCbSel;
  logic [7:0]       iLutIdx;
  logic [7:0]       iCbLutIdx;
  logic [7:0]       oUopAddr;
  logic [UOP_W-1:0] iUop;
  logic             oUopValid;
  logic             iStall;
  logic             iFlagZ;
  logic             oPcInc;
  logic             oInstrDone;
  logic             oBusy;
`ifdef DZCPU_USEQ_WATCHDOG_EN
  logic             oUopErr;
`endif
  modport master (
`ifdef DZCPU_USEQ_WATCHDOG_EN
    output oUopErr,
`endif
    output oFetchReq, oLutMop, oCbSel, oUopAddr, oUopValid, oPcInc, oInstrDone, oBusy,
    input  iMemValid, iMemData, iLutIdx, iCbLutIdx, iUop, iStall, iFlagZ
  );
  modport slave (
`ifdef DZCPU_USEQ_WATCHDOG_EN
    input  oUopErr,
`endif
    input  oFetchReq, oLutMop, oCbSel, oUopAddr, oUopValid, oPcInc, oInstrDone, oBusy,
    output iMemValid, iMemData, iLutIdx, iCbLutIdx, iUop, iStall, iFlagZ
  );
endinterface

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: micro-program sequencer (fetch, LUT decode with 0xCB two-level dispatch, ucode stepping).
// Define DZCPU_USEQ_WATCHDOG_EN to bound each instruction to MAX_UOPS issued uops and flag oUopErr.
module dzcpu_useq #(
  parameter int         UOP_W    = 12,
  parameter logic [4:0] JCB_OP   = 5'h1F,
  parameter int         MAX_UOPS = 32
) (
  input  logic          iClock,
  input  logic          iReset,
  dzcpu_useq_if.master  bus
);
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_upc, r_op;
  logic       r_cb;
  logic [2:0] w_flow;
  logic [4:0] w_opf;
  logic       w_adv, w_inc, w_eof, w_jcb, w_done;
`ifdef DZCPU_USEQ_WATCHDOG_EN
  localparam logic [5:0] WD_LAST = 6'(MAX_UOPS - 1);
  logic [5:0] r_cnt;
  logic       r_err, w_wd;
`endif
  assign w_flow = bus.iUop[UOP_W-1 -: 3];
  assign w_opf  = bus.iUop[UOP_W-4 -: 5];
  always_comb begin
    w_adv  = (r_state == S_EXEC) && !bus.iStall;
    w_inc  = w_adv && (w_flow == 3'd1 || w_flow == 3'd3);
    w_eof  = w_adv && (w_flow == 3'd2 || w_flow == 3'd3 || (w_flow == 3'd4 && bus.iFlagZ));
    w_jcb  = w_adv && (w_opf == JCB_OP);
    w_done = w_eof && !w_jcb;
`ifdef DZCPU_USEQ_WATCHDOG_EN
    // the last budgeted uop forces completion even over a CB jump
    w_wd   = w_adv && (r_cnt == WD_LAST) && !w_done;
    w_jcb  = w_jcb && !w_wd;
    w_done = w_done || w_wd;
`endif
    w_next = (r_state == S_FETCH)  ? (bus.iMemValid ? S_DECODE : S_FETCH) :
             (r_state == S_DECODE) ? S_EXEC :
             w_jcb                 ? S_DECODE :
             w_done                ? S_FETCH : S_EXEC;
  end
  always_ff @(posedge iClock or negedge iReset)
    if (!iReset) r_state <= S_FETCH;
    else         r_state <= w_next;
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_upc <= '0;
      r_op  <= '0;
      r_cb  <= 1'b0;
    end else begin
      if (r_state == S_FETCH && bus.iMemValid) begin
        r_op <= bus.iMemData;
        r_cb <= 1'b0;
      end
      if (r_state == S_DECODE) r_upc <= r_cb ? bus.iCbLutIdx : bus.iLutIdx;
      if (w_jcb) begin
        r_op <= bus.iMemData;
        r_cb <= 1'b1;
      end else if (w_done) r_cb <= 1'b0;
      else if (w_adv) r_upc <= r_upc + 8'd1;
    end
  end
`ifdef DZCPU_USEQ_WATCHDOG_EN
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_FETCH) ? 6'd0 : r_cnt + 6'(w_adv);
      if (w_wd) r_err <= 1'b1;
    end
  end
  assign bus.oUopErr = r_err;
`endif
  // the reset term keeps the fetch request low while reset is held
  assign bus.oFetchReq  = iReset && (r_state == S_FETCH);
  assign bus.oLutMop    = r_op;
  assign bus.oCbSel     = r_cb;
  assign bus.oUopAddr   = r_upc;
  assign bus.oUopValid  = w_adv;
  assign bus.oPcInc     = w_inc;
  assign bus.oInstrDone = w_done;
  assign bus.oBusy      = (r_state != S_FETCH);
endmodule
